// File: rtl/dlf_gear_ctrl.sv
// dlf_gear_ctrl: bandwidth gear-shift sequencer for the digital loop filter.
// Starts the loop on wide acquisition coefficients, watches |err| for lock,
// moves to narrow tracking coefficients once locked and falls back to
// acquisition when lock is lost.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | filter disabled, coefficients hold last value
// LOAD_ACQ | one cycle: load acquisition set, clear counters
// ACQ      | filter running, settle dwell before lock monitoring
// MONITOR  | count consecutive good samples toward lock
// SWITCH   | one cycle: load tracking set with filter kept running
// TRACK    | locked; count consecutive bad samples toward lock loss
// FAIL     | acquisition timed out, filter disabled, wait for start
module dlf_gear_ctrl #(
  parameter int CNT_W = 16,
  parameter int LCK_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      err_in,
  input  logic [63:0]      acq_coef,
  input  logic [63:0]      trk_coef,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic [15:0]      lock_thr,
  input  logic [15:0]      unlock_thr,
  input  logic [LCK_W-1:0] lock_cnt,
  output logic             dlf_en,
  output logic [15:0]      dlf_a2,
  output logic [15:0]      dlf_a3,
  output logic [15:0]      dlf_b1,
  output logic [15:0]      dlf_b2,
  output logic             locked,
  output logic             fail,
  output logic             lock_lost,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_ACQ = 3'd1,
    S_ACQ      = 3'd2,
    S_MONITOR  = 3'd3,
    S_SWITCH   = 3'd4,
    S_TRACK    = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_tmo;
  logic [LCK_W-1:0] r_good;
  logic [LCK_W-1:0] r_bad;

  logic [15:0]      w_err_mag;
  logic             w_good;
  logic             w_bad;
  logic [CNT_W-1:0] w_settle_req;
  logic [LCK_W-1:0] w_lock_req;
  logic [CNT_W-1:0] w_dwell_inc;
  logic [CNT_W-1:0] w_tmo_inc;
  logic [LCK_W-1:0] w_good_inc;
  logic [LCK_W-1:0] w_bad_inc;
  logic             w_dwell_done;
  logic             w_tmo_hit;
  logic             w_good_done;
  logic             w_bad_done;

  // Error magnitude; the most negative code saturates so it stays in 15 bits
  always_comb begin
    w_err_mag = err_in;
    if (err_in[15]) begin
      if (err_in == 16'h8000) w_err_mag = 16'h7fff;
      else                    w_err_mag = ~err_in + 16'd1;
    end
  end

  assign w_good = (w_err_mag <= lock_thr);
  assign w_bad  = (w_err_mag >  unlock_thr);

  // Zero-valued dwell and lock counts behave as one cycle / one sample
  assign w_settle_req = (settle_cycles == '0) ? CNT_W'(1) : settle_cycles;
  assign w_lock_req   = (lock_cnt == '0)      ? LCK_W'(1) : lock_cnt;

  assign w_dwell_inc  = r_dwell + CNT_W'(1);
  assign w_tmo_inc    = r_tmo + CNT_W'(1);
  assign w_good_inc   = w_good ? (r_good + LCK_W'(1)) : '0;
  assign w_bad_inc    = w_bad  ? (r_bad + LCK_W'(1))  : '0;

  assign w_dwell_done = (w_dwell_inc >= w_settle_req);
  assign w_tmo_hit    = (timeout_cycles != '0) && (w_tmo_inc == timeout_cycles);
  assign w_good_done  = (w_good_inc >= w_lock_req);
  assign w_bad_done   = (w_bad_inc >= w_lock_req);

  // Next-state decode; stop wins over everything, timeout wins over progress
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start) w_state_nxt = S_LOAD_ACQ;
        S_LOAD_ACQ: w_state_nxt = S_ACQ;
        S_ACQ: begin
          if (w_tmo_hit)         w_state_nxt = S_FAIL;
          else if (w_dwell_done) w_state_nxt = S_MONITOR;
        end
        S_MONITOR: begin
          if (w_tmo_hit)        w_state_nxt = S_FAIL;
          else if (w_good_done) w_state_nxt = S_SWITCH;
        end
        S_SWITCH:   w_state_nxt = S_TRACK;
        S_TRACK:    if (w_bad_done) w_state_nxt = S_LOAD_ACQ;
        S_FAIL:     if (start) w_state_nxt = S_LOAD_ACQ;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register with outputs registered from the state being entered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      dlf_en    <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      dlf_en    <= (w_state_nxt == S_ACQ)    || (w_state_nxt == S_MONITOR) ||
                   (w_state_nxt == S_SWITCH) || (w_state_nxt == S_TRACK);
      locked    <= (w_state_nxt == S_TRACK);
      fail      <= (w_state_nxt == S_FAIL);
      lock_lost <= (r_state == S_TRACK) && (w_state_nxt == S_LOAD_ACQ);
    end
  end

  // Coefficient buses only change in the two load states; stop aborts a load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dlf_a2 <= '0;
      dlf_a3 <= '0;
      dlf_b1 <= '0;
      dlf_b2 <= '0;
    end else if (!stop && (r_state == S_LOAD_ACQ)) begin
      {dlf_a2, dlf_a3, dlf_b1, dlf_b2} <= acq_coef;
    end else if (!stop && (r_state == S_SWITCH)) begin
      {dlf_a2, dlf_a3, dlf_b1, dlf_b2} <= trk_coef;
    end
  end

  // Dwell, timeout and consecutive-sample counters; cleared outside their phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dwell <= '0;
      r_tmo   <= '0;
      r_good  <= '0;
      r_bad   <= '0;
    end else begin
      case (r_state)
        S_ACQ: begin
          r_dwell <= w_dwell_inc;
          r_tmo   <= w_tmo_inc;
        end
        S_MONITOR: begin
          r_tmo  <= w_tmo_inc;
          r_good <= w_good_inc;
        end
        S_TRACK: begin
          r_bad <= w_bad_inc;
        end
        default: begin
          r_dwell <= '0;
          r_tmo   <= '0;
          r_good  <= '0;
          r_bad   <= '0;
        end
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// Bench for dlf_gear_ctrl: directed scenarios followed by a random run, all
// checked every cycle against a phase-level reference model.
module tb_dlf_gear_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        stop;
  logic [15:0] err_in;
  logic [63:0] acq_coef;
  logic [63:0] trk_coef;
  logic [15:0] settle_cycles;
  logic [15:0] timeout_cycles;
  logic [15:0] lock_thr;
  logic [15:0] unlock_thr;
  logic [7:0]  lock_cnt;
  logic        dlf_en;
  logic [15:0] dlf_a2, dlf_a3, dlf_b1, dlf_b2;
  logic        locked;
  logic        fail;
  logic        lock_lost;
  logic [2:0]  state;

  int n_chk;
  int n_fail;

  // reference model: phase numbers follow the published state encoding
  int          m_ph;
  int          m_acq, m_tmo, m_good, m_bad;
  logic [63:0] m_coef;
  bit          m_en, m_lk, m_fl, m_lost;

  dlf_gear_ctrl #(.CNT_W(16), .LCK_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .err_in(err_in),
    .acq_coef(acq_coef), .trk_coef(trk_coef), .settle_cycles(settle_cycles),
    .timeout_cycles(timeout_cycles), .lock_thr(lock_thr), .unlock_thr(unlock_thr),
    .lock_cnt(lock_cnt), .dlf_en(dlf_en), .dlf_a2(dlf_a2), .dlf_a3(dlf_a3),
    .dlf_b1(dlf_b1), .dlf_b2(dlf_b2), .locked(locked), .fail(fail),
    .lock_lost(lock_lost), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mag(logic [15:0] e);
    int v;
    v = int'($signed(e));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_acq = 0; m_tmo = 0; m_good = 0; m_bad = 0;
    m_coef = '0; m_en = 0; m_lk = 0; m_fl = 0; m_lost = 0;
  endtask

  task automatic model_edge();
    int lreq, sreq, nx;
    bit tmo_hit;
    lreq = (lock_cnt == 0) ? 1 : int'(lock_cnt);
    sreq = (settle_cycles == 0) ? 1 : int'(settle_cycles);
    nx = m_ph;
    m_lost = 0;
    if (stop) nx = 0;
    else begin
      case (m_ph)
        0: if (start) nx = 1;
        1: begin m_coef = acq_coef; m_acq = 0; m_tmo = 0; m_good = 0; nx = 2; end
        2: begin
          m_acq++; m_tmo++;
          tmo_hit = (timeout_cycles != 0) && (m_tmo == int'(timeout_cycles));
          if (tmo_hit) nx = 6; else if (m_acq == sreq) nx = 3;
        end
        3: begin
          m_tmo++;
          m_good = (mag(err_in) <= int'(lock_thr)) ? m_good + 1 : 0;
          tmo_hit = (timeout_cycles != 0) && (m_tmo == int'(timeout_cycles));
          if (tmo_hit) nx = 6; else if (m_good == lreq) nx = 4;
        end
        4: begin m_coef = trk_coef; m_bad = 0; nx = 5; end
        5: begin
          m_bad = (mag(err_in) > int'(unlock_thr)) ? m_bad + 1 : 0;
          if (m_bad == lreq) begin m_lost = 1; nx = 1; end
        end
        6: if (start) nx = 1;
        default: nx = 0;
      endcase
    end
    m_ph = nx;
    m_en = (nx >= 2 && nx <= 5);
    m_lk = (nx == 5);
    m_fl = (nx == 6);
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_ph));
    chk("dlf_en", 64'(dlf_en), 64'(m_en));
    chk("coef", {dlf_a2, dlf_a3, dlf_b1, dlf_b2}, m_coef);
    chk("locked", 64'(locked), 64'(m_lk));
    chk("fail", 64'(fail), 64'(m_fl));
    chk("lock_lost", 64'(lock_lost), 64'(m_lost));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_until(int ph, int maxc, string tag);
    int n;
    n = 0;
    while (m_ph != ph && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 64'(state), 64'(ph));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int tmo_n;
    int v;
    logic [63:0] acq_save;
    n_chk = 0; n_fail = 0;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; err_in = '0;
    acq_coef = {$urandom, $urandom};
    trk_coef = {$urandom, $urandom};
    settle_cycles = 16'd4; timeout_cycles = 16'd0;
    lock_thr = 16'd10; unlock_thr = 16'd50; lock_cnt = 8'd3;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_state", 64'(state), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // basic acquisition to tracking, err constant 5
    err_in = 16'd5;
    pulse_start();
    chk("t1_load", 64'(state), 64'd1);
    run_until(5, 20, "t1_track");
    chk("t1_coef_trk", {dlf_a2, dlf_a3, dlf_b1, dlf_b2}, trk_coef);
    chk("t1_locked", 64'(locked), 64'd1);

    // good-count restart in MONITOR: 5,5,20,5,5,5
    stop = 1'b1; tick(); stop = 1'b0;
    settle_cycles = 16'd2; err_in = 16'd100;
    pulse_start();
    run_until(3, 10, "t2_monitor");
    err_in = 16'd5;  tick();
    err_in = 16'd5;  tick();
    err_in = 16'd20; tick();
    err_in = 16'd5;  tick();
    err_in = 16'd5;  tick();
    chk("t2_still_mon", 64'(state), 64'd3);
    err_in = 16'd5;  tick();
    chk("t2_switch", 64'(state), 64'd4);
    err_in = 16'd0;  tick();
    chk("t2_track", 64'(state), 64'd5);

    // lock loss in TRACK: 60,0,60 holds, 60,60 drops
    lock_cnt = 8'd2; unlock_thr = 16'd50;
    acq_save = acq_coef;
    err_in = 16'd60; tick();
    err_in = 16'd0;  tick();
    err_in = 16'd60; tick();
    chk("t3_hold", 64'(state), 64'd5);
    err_in = 16'd0;  tick();
    err_in = 16'd60; tick();
    err_in = 16'd60; tick();
    chk("t3_lost", 64'(lock_lost), 64'd1);
    chk("t3_load", 64'(state), 64'd1);
    chk("t3_unlocked", 64'(locked), 64'd0);
    err_in = 16'd0;  tick();
    chk("t3_pulse_end", 64'(lock_lost), 64'd0);
    chk("t3_coef_acq", {dlf_a2, dlf_a3, dlf_b1, dlf_b2}, acq_save);

    // timeout: 10 cycles in ACQ+MONITOR then FAIL
    stop = 1'b1; tick(); stop = 1'b0;
    timeout_cycles = 16'd10; settle_cycles = 16'd4; lock_cnt = 8'd3;
    err_in = 16'd1000;
    pulse_start();
    tmo_n = 0;
    for (int i = 0; i < 20 && m_ph != 6; i++) begin
      tick();
      if (state == 3'd2 || state == 3'd3) tmo_n++;
    end
    chk("t4_tmo_cycles", 64'(tmo_n), 64'd10);
    chk("t4_fail_state", 64'(state), 64'd6);
    chk("t4_fail", 64'(fail), 64'd1);
    chk("t4_en_off", 64'(dlf_en), 64'd0);
    pulse_start();
    chk("t4_restart", 64'(state), 64'd1);

    // saturated magnitude of -32768 counts as good with lock_thr 32767
    timeout_cycles = 16'd0; settle_cycles = 16'd1; lock_cnt = 8'd1;
    lock_thr = 16'd32767; err_in = 16'h8000;
    tick();
    tick();
    tick();
    chk("t5_sat_good", 64'(state), 64'd4);

    // stop coincident with start in FAIL returns to IDLE
    stop = 1'b1; tick(); stop = 1'b0;
    timeout_cycles = 16'd3; settle_cycles = 16'd5;
    pulse_start();
    run_until(6, 10, "t5_fail");
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t5_stop_wins", 64'(state), 64'd0);

    // random run
    for (int i = 0; i < 800; i++) begin
      if ((m_ph == 0 || m_ph == 6) && $urandom_range(3) == 0) begin
        settle_cycles  = 16'($urandom_range(5));
        lock_cnt       = 8'($urandom_range(4));
        lock_thr       = 16'($urandom_range(40));
        unlock_thr     = 16'($urandom_range(80, 20));
        timeout_cycles = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(40, 8));
      end
      if ($urandom_range(15) == 0) acq_coef = {$urandom, $urandom};
      if ($urandom_range(15) == 0) trk_coef = {$urandom, $urandom};
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(59) == 0);
      case ($urandom_range(3))
        0: v = int'($urandom_range(30)) - 15;
        1: v = int'($urandom_range(200)) - 100;
        2: v = int'($urandom_range(65535)) - 32768;
        default: v = ($urandom_range(1) == 0) ? -32768 : 32767;
      endcase
      err_in = v[15:0];
      tick();
    end
    start = 1'b0; stop = 1'b0;

    // asynchronous reset while in TRACK
    stop = 1'b1; tick(); stop = 1'b0;
    settle_cycles = 16'd1; lock_cnt = 8'd1; lock_thr = 16'd10;
    unlock_thr = 16'd100; timeout_cycles = 16'd0; err_in = 16'd0;
    pulse_start();
    run_until(5, 10, "t6_track");
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_state", 64'(state), 64'd0);
    chk("t6_rst_coef", {dlf_a2, dlf_a3, dlf_b1, dlf_b2}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_stay_idle", 64'(state), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
